// File: rtl/lcd_responder.sv
// HD44780-compatible bus responder: decodes host strobes, tracks AC and display
// flags, and answers busy/address status reads.
module lcd_responder #(
  parameter int BUSY_CYCLES = 37,
  parameter int LONG_CYCLES = 1520
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [3:0] LCD_D,
  input  logic       LCD_E,
  input  logic       LCD_RW,
  input  logic       LCD_RS,
  output logic [3:0] LCD_D_OUT,
  output logic       LCD_D_OE,
  output logic       busy_flag,
  output logic       cmd_valid,
  output logic       cmd_rs,
  output logic [7:0] cmd_byte,
  output logic [6:0] addr,
  output logic       mode4bit,
  output logic       display_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       entry_id,
  output logic       entry_s,
  output logic       protocol_err
);

  localparam int MAX_CYCLES = (LONG_CYCLES > BUSY_CYCLES) ? LONG_CYCLES : BUSY_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);

  logic          e_s, e_s_d, rw_s, rs_s;
  logic [3:0]    d_s;
  logic          phase;   // 0 = expecting high nibble, 1 = expecting low nibble
  logic [3:0]    hi_nib;
  logic [CW-1:0] count;

  logic          fall, busy, byte_done, wr_ok, wr_err;
  logic [7:0]    byte_in;

  assign fall      = e_s_d & ~e_s;
  assign busy      = (count != '0);
  assign busy_flag = busy;

  always_comb begin
    byte_done = fall & (~mode4bit | phase);
    byte_in   = mode4bit ? {hi_nib, d_s} : {d_s, 4'b0000};
    wr_ok     = byte_done & ~rw_s & ~busy;
    wr_err    = byte_done & ~rw_s & busy;
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      e_s          <= 1'b0;
      e_s_d        <= 1'b0;
      rw_s         <= 1'b0;
      rs_s         <= 1'b0;
      d_s          <= 4'h0;
      phase        <= 1'b0;
      hi_nib       <= 4'h0;
      count        <= '0;
      LCD_D_OUT    <= 4'h0;
      LCD_D_OE     <= 1'b0;
      cmd_valid    <= 1'b0;
      cmd_rs       <= 1'b0;
      cmd_byte     <= 8'h00;
      addr         <= 7'h00;
      mode4bit     <= 1'b0;
      display_on   <= 1'b0;
      cursor_on    <= 1'b0;
      blink_on     <= 1'b0;
      entry_id     <= 1'b1;
      entry_s      <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      e_s          <= LCD_E;
      e_s_d        <= e_s;
      d_s          <= LCD_D;
      rw_s         <= LCD_RW;
      rs_s         <= LCD_RS;
      cmd_valid    <= 1'b0;
      protocol_err <= wr_err;
      LCD_D_OE     <= e_s & rw_s;

      if (rs_s)
        LCD_D_OUT <= 4'h0;
      else if (mode4bit && phase)
        LCD_D_OUT <= addr[3:0];
      else
        LCD_D_OUT <= {busy, addr[6:4]};

      if (busy)
        count <= count - 1'b1;

      // Reads advance the nibble phase too, so host and responder stay paired.
      if (fall && mode4bit) begin
        phase <= ~phase;
        if (!phase)
          hi_nib <= d_s;
      end

      if (wr_ok) begin
        cmd_valid <= 1'b1;
        cmd_rs    <= rs_s;
        cmd_byte  <= byte_in;
        if (rs_s) begin
          addr  <= entry_id ? addr + 7'd1 : addr - 7'd1;
          count <= CW'(BUSY_CYCLES);
        end else begin
          if (byte_in != 8'd0)
            count <= (byte_in <= 8'd3) ? CW'(LONG_CYCLES) : CW'(BUSY_CYCLES);
          casez (byte_in)
            8'b1???????: addr <= byte_in[6:0];
            8'b01??????: begin end  // CGRAM address: AC untouched
            8'b001?????: begin
              mode4bit <= ~byte_in[4];
              phase    <= 1'b0;
            end
            8'b0001????: begin
              if (!byte_in[3])
                addr <= byte_in[2] ? addr + 7'd1 : addr - 7'd1;
            end
            8'b00001???: begin
              display_on <= byte_in[2];
              cursor_on  <= byte_in[1];
              blink_on   <= byte_in[0];
            end
            8'b000001??: begin
              entry_id <= byte_in[1];
              entry_s  <= byte_in[0];
            end
            8'b0000001?: addr <= 7'h00;
            8'b00000001: begin
              addr     <= 7'h00;
              entry_id <= 1'b1;
            end
            default: begin end
          endcase
        end
      end
    end
  end

endmodule
